vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical counters, sync pulses, a display-active `blank` flag and the `DrawX`/`DrawY` pixel coordinates. It sits directly upstream of every pixel-drawing stage, including the text/sprite renderers, the palette lookups and the final colour mux. It also provides a frame-start pulse and frame counter for game logic. Optional sync delay outputs align `hs`/`vs` with the two-cycle ROM+register latency of downstream renderers.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_sync_delay.sv | 24 ++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, coordinate types and a window-decode helper.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF  = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_VISIBLE_DEF  = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int H_TOTAL_DEF    = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF    = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int SYNC_DELAY_DEF = 2;

    typedef logic [9:0] coord_t;
    typedef logic [7:0] frame_cnt_t;

    // True when lo <= v < lo+len.
    function automatic logic in_window(input coord_t v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-deep shift register for the {hs, vs} pair; resets to all-ones (syncs inactive).
module vga_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] sr [DEPTH];

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= 2'b11;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, registered sync/blank decode, frame pulse and counter.
// Define VGA_SYNC_DELAY_EN to delay hs_d/vs_d by SYNC_DELAY clocks; otherwise they equal hs/vs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_ce,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output frame_cnt_t frame_count,
    output logic       hs_d,
    output logic       vs_d
);

    localparam int     H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > 1024) begin : g_htot_chk
        $error("vga_timing_gen: horizontal total %0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_vtot_chk
        $error("vga_timing_gen: vertical total %0d exceeds 1024", V_TOTAL);
    end
    if (SYNC_DELAY < 1) begin : g_dly_chk
        $error("vga_timing_gen: SYNC_DELAY must be at least 1");
    end

    coord_t x_nx;
    coord_t y_nx;
    logic   end_line;
    logic   end_frame;

    always_comb begin
        end_line  = (DrawX == H_LAST);
        end_frame = end_line && (DrawY == V_LAST);
        x_nx      = end_line ? '0 : DrawX + coord_t'(1);
        y_nx      = DrawY;
        if (end_line) y_nx = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
    end

    // Sync and blank decode from the next counter values so they land with DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (pix_ce) begin
            DrawX       <= x_nx;
            DrawY       <= y_nx;
            hs          <= !in_window(x_nx, H_VISIBLE + H_FP, H_SYNC);
            vs          <= !in_window(y_nx, V_VISIBLE + V_FP, V_SYNC);
            blank       <= (int'(x_nx) < H_VISIBLE) && (int'(y_nx) < V_VISIBLE);
            frame_start <= end_frame;
            if (end_frame) frame_count <= frame_count + frame_cnt_t'(1);
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] sync_dly;

    vga_sync_delay #(
        .DEPTH   (SYNC_DELAY)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .reset   (reset),
        .din     ({hs, vs}),
        .dout    (sync_dly)
    );

    assign {hs_d, vs_d} = sync_dly;
`else
    assign hs_d = hs;
    assign vs_d = vs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench: a full-size generator and a tiny-raster generator checked against a tick-count model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Tiny raster (8 x 6 = 48 ticks per frame) so frame wrap and frame_count wrap fit the run.
    localparam int SH_VIS = 4, SH_FP = 1, SH_SYNC = 2, SH_BP = 1;
    localparam int SV_VIS = 3, SV_FP = 1, SV_SYNC = 1, SV_BP = 1;
    localparam int S_FRAME = (SH_VIS + SH_FP + SH_SYNC + SH_BP) * (SV_VIS + SV_FP + SV_SYNC + SV_BP);
`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit blank;
        bit fs;
        int fc;
    } exp_t;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       pix_ce  = 1'b0;

    coord_t     a_x, a_y, b_x, b_y;
    logic       a_hs, a_vs, a_blank, a_fs, a_hsd, a_vsd;
    logic       b_hs, b_vs, b_blank, b_fs, b_hsd, b_vsd;
    frame_cnt_t a_fc, b_fc;

    int         n_cmp = 0;
    int         n_mis = 0;
    longint     n_tick = 0;
    bit         last_ce = 1'b0;
    logic [1:0] hist_a [3];
    logic [1:0] hist_b [3];

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut_a (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (a_x),
        .DrawY       (a_y),
        .hs          (a_hs),
        .vs          (a_vs),
        .blank       (a_blank),
        .frame_start (a_fs),
        .frame_count (a_fc),
        .hs_d        (a_hsd),
        .vs_d        (a_vsd)
    );

    vga_timing_gen #(
        .H_VISIBLE (SH_VIS), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
        .V_VISIBLE (SV_VIS), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP)
    ) u_dut_b (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (b_x),
        .DrawY       (b_y),
        .hs          (b_hs),
        .vs          (b_vs),
        .blank       (b_blank),
        .frame_start (b_fs),
        .frame_count (b_fc),
        .hs_d        (b_hsd),
        .vs_d        (b_vsd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Raster position follows directly from the number of enabled ticks since reset.
    function automatic exp_t model(input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        exp_t   e;
        int     ht = hv + hf + hsw + hb;
        int     vt = vv + vf + vsw + vb;
        longint fr = longint'(ht) * vt;
        e.x     = int'(n_tick % ht);
        e.y     = int'((n_tick / ht) % vt);
        e.fc    = int'((n_tick / fr) % 256);
        e.hs    = !(e.x >= hv + hf && e.x < hv + hf + hsw);
        e.vs    = !(e.y >= vv + vf && e.y < vv + vf + vsw);
        e.blank = (e.x < hv) && (e.y < vv);
        e.fs    = last_ce && (n_tick > 0) && (n_tick % fr == 0);
        return e;
    endfunction

    function automatic exp_t model_a();
        return model(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
                     V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
    endfunction

    function automatic exp_t model_b();
        return model(SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP);
    endfunction

    task automatic check_all();
        exp_t ea = model_a();
        exp_t eb = model_b();
        chk("a.DrawX", a_x, ea.x);
        chk("a.DrawY", a_y, ea.y);
        chk("a.hs", a_hs, ea.hs);
        chk("a.vs", a_vs, ea.vs);
        chk("a.blank", a_blank, ea.blank);
        chk("a.frame_start", a_fs, ea.fs);
        chk("a.frame_count", a_fc, ea.fc);
        chk("a.hs_d", a_hsd, hist_a[DLY][1]);
        chk("a.vs_d", a_vsd, hist_a[DLY][0]);
        chk("b.DrawX", b_x, eb.x);
        chk("b.DrawY", b_y, eb.y);
        chk("b.hs", b_hs, eb.hs);
        chk("b.vs", b_vs, eb.vs);
        chk("b.blank", b_blank, eb.blank);
        chk("b.frame_start", b_fs, eb.fs);
        chk("b.frame_count", b_fc, eb.fc);
        chk("b.hs_d", b_hsd, hist_b[DLY][1]);
        chk("b.vs_d", b_vsd, hist_b[DLY][0]);
    endtask

    task automatic model_reset();
        n_tick  = 0;
        last_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hist_a[i] = 2'b11;
            hist_b[i] = 2'b11;
        end
    endtask

    // One clock: apply enable, advance the model at the edge, check 1 time unit later.
    task automatic step(input bit ce);
        exp_t ea, eb;
        pix_ce = ce;
        @(posedge vga_clk);
        n_tick  += ce;
        last_ce  = ce;
        ea = model_a();
        eb = model_b();
        for (int i = 2; i > 0; i--) begin
            hist_a[i] = hist_a[i-1];
            hist_b[i] = hist_b[i-1];
        end
        hist_a[0] = {ea.hs, ea.vs};
        hist_b[0] = {eb.hs, eb.vs};
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released mid-cycle.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge vga_clk);
        #1 check_all();
        #3 reset = 1'b0;
    endtask

    initial begin
        int steps;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all();
        @(posedge vga_clk);
        #1 check_all();
        #3 reset = 1'b0;

        // Free-running: more than two full lines of the full-size raster.
        for (int i = 0; i < 2000; i++) step(1'b1);

        // Enable on alternate clocks: a full-size line spans 1600 clocks.
        for (int i = 0; i < 3200; i++) step(i[0] == 1'b0);

        // Random enable until the tiny raster has passed 256 frames (frame_count wraps).
        steps = 0;
        while (n_tick < 256 * S_FRAME + 100 && steps < 30000) begin
            step($urandom_range(0, 3) != 0);
            steps++;
        end
        chk("wrap_reached_in_budget", (n_tick >= 256 * S_FRAME + 100), 1);

        // Reset in the middle of the sixth tiny frame after frame_count reached 5.
        pulse_reset();
        for (int i = 0; i < 5 * S_FRAME + 20; i++) step(1'b1);
        chk("b.frame_count_before_reset", b_fc, 5);
        pulse_reset();
        chk("b.frame_count_after_reset", b_fc, 0);

        for (int i = 0; i < 600; i++) step($urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
